// File: rtl/comp_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : comp_serial_if
//  Description : Handshake/operand bundle for the bit-serial comparator.
//                master drives start/a/b and observes status/result;
//                slave (the comparator) does the reverse.
//  Signals     : start        - compare request, honoured only while idle
//                a, b         - WIDTH-bit unsigned operands
//                busy         - compare in progress
//                done         - one-cycle completion pulse
//                gt, eq, lt   - one-hot result of the last completed compare
//  Revision    : 1.0  initial release
// ============================================================================
interface comp_serial_if #(
  parameter int WIDTH = 2
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt
  );
endinterface
`default_nettype wire

// File: rtl/comp_serial.sv
`default_nettype none
// ============================================================================
//  Module      : comp_serial
//  Description : Bit-serial unsigned magnitude comparator. Operands are
//                captured on an accepted start and examined one bit pair
//                per clock, MSB first. The result is a registered one-hot
//                gt/eq/lt with a single-cycle done pulse, WIDTH cycles after
//                the accepting edge. Latency is fixed (no early exit).
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - comp_serial_if.slave (start, a, b in;
//                         busy, done, gt, eq, lt out)
//  Parameters  : WIDTH  - operand width, 1..32
//  Revision    : 1.0  initial release
// ============================================================================
module comp_serial #(
  parameter int WIDTH = 2
) (
  input  wire          clk,
  input  wire          rst_n,
  comp_serial_if.slave bus
);

  // Bit counter is clog2(WIDTH) bits but never narrower than one bit,
  // so the WIDTH=1 build still has a legal counter holding 0.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] DEC_EQ = 2'b00;
  localparam logic [1:0] DEC_GT = 2'b01;
  localparam logic [1:0] DEC_LT = 2'b10;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q,    sa_d;
  logic [WIDTH-1:0] sb_q,    sb_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       dec_q,   dec_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             gt_q,    gt_d;
  logic             eq_q,    eq_d;
  logic             lt_q,    lt_d;

  // Decision after folding in the current MSB pair. Only the first
  // differing pair can move the decision away from EQ; after that it
  // stays frozen for the rest of the compare.
  logic [1:0]       dec_nxt;
  logic             bit_a;
  logic             bit_b;

  assign bit_a = sa_q[WIDTH-1];
  assign bit_b = sb_q[WIDTH-1];

  always_comb begin
    dec_nxt = dec_q;
    if ((dec_q == DEC_EQ) && (bit_a != bit_b)) begin
      dec_nxt = bit_a ? DEC_GT : DEC_LT;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cnt_d   = CNT_W'(WIDTH - 1);
          dec_d   = DEC_EQ;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // start and operand changes are ignored here; the in-flight
        // compare works only from the captured shift registers.
        dec_d = dec_nxt;
        sa_d  = sa_q << 1;
        sb_d  = sb_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          // Final pair: the result includes this bit's contribution.
          gt_d    = (dec_nxt == DEC_GT);
          eq_d    = (dec_nxt == DEC_EQ);
          lt_d    = (dec_nxt == DEC_LT);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      dec_q   <= DEC_EQ;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = gt_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;

endmodule
`default_nettype wire

// File: tb/tb_comp_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_serial
//  Description : Bench for comp_serial at WIDTH 2, 4 and 8. Expected
//                results are queued with their accepting cycle when a start
//                is driven that the comparator must accept; monitors pop and
//                compare on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_comp_serial;

  typedef struct {
    logic [2:0] res;   // {gt, eq, lt}
    int         acc;   // cycle number of the accepting edge
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  exp_t q2[$];
  exp_t q4[$];
  exp_t q8[$];

  comp_serial_if #(.WIDTH(2)) bus2 ();
  comp_serial_if #(.WIDTH(4)) bus4 ();
  comp_serial_if #(.WIDTH(8)) bus8 ();

  comp_serial #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  comp_serial #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  comp_serial #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  // Pop the oldest expectation for width w and compare it with a done pulse.
  task automatic on_done(input int w, input logic bz, input logic [2:0] got);
    exp_t e;
    int   n;
    case (w)
      2:       n = q2.size();
      4:       n = q4.size();
      default: n = q8.size();
    endcase
    chk($sformatf("done_expected_w%0d", w), (n > 0), 1'b1);
    if (n == 0) return;
    case (w)
      2:       e = q2.pop_front();
      4:       e = q4.pop_front();
      default: e = q8.pop_front();
    endcase
    chk($sformatf("result_w%0d", w), got, e.res);
    chk($sformatf("onehot_w%0d", w), $countones(got), 1);
    chk($sformatf("latency_w%0d", w), cyc - e.acc, w);
    chk($sformatf("busy_at_done_w%0d", w), bz, 1'b0);
  endtask

  always @(negedge clk) if (bus2.done) on_done(2, bus2.busy, {bus2.gt, bus2.eq, bus2.lt});
  always @(negedge clk) if (bus4.done) on_done(4, bus4.busy, {bus4.gt, bus4.eq, bus4.lt});
  always @(negedge clk) if (bus8.done) on_done(8, bus8.busy, {bus8.gt, bus8.eq, bus8.lt});

  // Drive start for one edge on instance w; optionally record the expectation.
  task automatic go(input int w, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    @(negedge clk);
    case (w)
      2:       begin bus2.start = 1'b1; bus2.a = a[1:0]; bus2.b = b[1:0]; end
      4:       begin bus4.start = 1'b1; bus4.a = a[3:0]; bus4.b = b[3:0]; end
      default: begin bus8.start = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0]; end
    endcase
    e.res = ref_cmp(a, b);
    e.acc = cyc + 1;
    if (push) begin
      case (w)
        2:       q2.push_back(e);
        4:       q4.push_back(e);
        default: q8.push_back(e);
      endcase
    end
    @(negedge clk);
    bus2.start = 1'b0;
    bus4.start = 1'b0;
    bus8.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && (q2.size() + q4.size() + q8.size()) != 0; k++)
      @(negedge clk);
    chk("drain_timeout", q2.size() + q4.size() + q8.size(), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy",   {bus2.busy, bus4.busy, bus8.busy}, 3'b000);
    chk("rst_done",   {bus2.done, bus4.done, bus8.done}, 3'b000);
    chk("rst_result", {bus2.gt, bus2.eq, bus2.lt, bus8.gt, bus8.eq, bus8.lt}, 6'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exhaustive WIDTH=2 sweep.
    for (int i = 0; i < 16; i++) begin
      go(2, i[3:2], i[1:0], 1'b1);
      wait_idle();
    end

    // Latency detail, WIDTH=2: a=1, b=2.
    @(negedge clk);
    bus2.start = 1'b1; bus2.a = 2'd1; bus2.b = 2'd2;
    begin
      exp_t e;
      e.res = 3'b001;
      e.acc = cyc + 1;
      q2.push_back(e);
    end
    @(negedge clk);                       // after edge E
    bus2.start = 1'b0;
    chk("lat_busy_e0", bus2.busy, 1'b1);
    @(negedge clk);                       // after edge E+1
    chk("lat_busy_e1", bus2.busy, 1'b1);
    chk("lat_nodone_e1", bus2.done, 1'b0);
    @(negedge clk);                       // after edge E+2
    chk("lat_done_e2", {bus2.done, bus2.lt, bus2.busy}, 3'b110);
    @(negedge clk);                       // after edge E+3
    chk("lat_done_low_e3", bus2.done, 1'b0);
    chk("lat_hold_lt", bus2.lt, 1'b1);
    wait_idle();

    // Start ignored while busy, WIDTH=8.
    go(8, 32'h80, 32'h7F, 1'b1);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    chk("ignored_start_hold_gt", {bus8.gt, bus8.eq, bus8.lt}, 3'b100);

    // Bit-position cases, WIDTH=8.
    go(8, 32'h01, 32'h00, 1'b1); wait_idle();
    go(8, 32'hA5, 32'hA5, 1'b1); wait_idle();
    go(8, 32'h7F, 32'h80, 1'b1); wait_idle();

    // Reset mid-compare, WIDTH=8: aborted compare must not report.
    go(8, 32'd5, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus8.busy, 1'b0);
    chk("abort_result", {bus8.gt, bus8.eq, bus8.lt}, 3'b000);
    chk("abort_done", bus8.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_still_idle", bus8.busy, 1'b0);
    go(8, 32'd3, 32'd5, 1'b1);
    wait_idle();

    // Back-to-back, WIDTH=4: start held, operands changing every cycle;
    // only the values on each accepting edge matter.
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.a = 4'($urandom_range(0, 15));
      bus4.b = 4'($urandom_range(0, 15));
      if (j == 5) bus4.b = bus4.a;
      if (j % 5 == 0) begin
        exp_t e;
        e.res = ref_cmp({28'd0, bus4.a}, {28'd0, bus4.b});
        e.acc = cyc + 1;
        q4.push_back(e);
      end
    end
    @(negedge clk);
    bus4.start = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comp_serial.md
# comp_serial

Bit-serial magnitude comparator for the 2-bit-and-up comparator family. It captures two WIDTH-bit operands on a start strobe and examines one bit pair per clock, MSB first. It then returns a registered one-hot gt/eq/lt result with a single-cycle done pulse. It is the sequential counterpart of the combinational comparator: the same {a,b} stimulus the comparator bench drives is consumed here over WIDTH cycles instead of one.

## Interface
- WIDTH, 2, operand width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Assertion clears state immediately; deassertion is synchronous to clk.
- start  input  1  request a compare; sampled only while idle.
- a  input  WIDTH  operand A, unsigned; sampled on the accepting edge only.
- b  input  WIDTH  operand B, unsigned; sampled on the accepting edge only.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse; gt/eq/lt are valid from this cycle on.
- gt  output  1  a > b for the last completed compare.
- eq  output  1  a == b for the last completed compare.
- lt  output  1  a < b for the last completed compare.

## Operation
- States: IDLE, RUN.
- IDLE with start=1 at a rising edge:
  - Load sa<=a and sb<=b.
  - Load bit counter cnt<=WIDTH-1.
  - Clear the internal decision register dec<=EQUAL.
  - Go to RUN. busy goes high.
- RUN, each edge:
  - Compare sa[WIDTH-1] with sb[WIDTH-1].
  - If dec==EQUAL and the bits differ, set dec<=GREATER when the a bit is 1, else LESS.
  - Once dec is GREATER or LESS it is frozen.
  - Shift sa and sb left by one and decrement cnt.
- RUN with cnt==0 at an edge:
  - The final bit pair is evaluated with the same rule.
  - Load gt/eq/lt from the final decision, including this bit.
  - Assert done and go to IDLE.
- No early termination: latency is fixed regardless of where the first difference lies.
- All arithmetic is unsigned. cnt is clog2(WIDTH) bits wide, minimum 1 bit.
- Start handling:
  - start while busy is ignored; no queuing, and the in-flight result is unaffected.
  - Changes on a/b while busy are ignored.
- Result hold: gt/eq/lt hold their values until the next done. Exactly one is high after any completed compare.
- Reset, at any time including mid-compare:
  - busy=0, done=0, gt=0, eq=0, lt=0, state IDLE, shift registers and dec cleared.
  - An aborted compare never produces done.

## Timing
- Reset values: busy 0, done 0, gt 0, eq 0, lt 0.
- Start accepted at edge E:
  - busy is 1 from after E until after E+WIDTH.
  - gt/eq/lt update and done=1 in the cycle following edge E+WIDTH.
  - busy is 0 in that same cycle.
  - Latency is WIDTH cycles from the accepting edge to done.
- done is high for exactly one cycle and returns to 0 after edge E+WIDTH+1 unless a new compare completes there. A new compare cannot complete there, since WIDTH≥1.
- Earliest next accept is edge E+WIDTH+1 (start may be high during the done cycle). This gives one result per WIDTH+1 cycles with start held high.
- WIDTH=1: busy for one cycle, done in the cycle after E+1.

## Test plan
- Exhaustive sweep, WIDTH=2: for i=0..15, set {a,b}=i, pulse start, wait for done.
  - Require gt==(a>b), eq==(a==b), lt==(a<b), one-hot.
  - Example: a=2, b=1 -> 1 0 0; a=3, b=3 -> 0 1 0.
- Latency, WIDTH=2: start=1 at edge 0 with a=1, b=2.
  - busy=1 after edges 0 and 1.
  - done=1 and lt=1 only after edge 2, then done=0 after edge 3.
- Start ignored while busy, WIDTH=8:
  - Accept a=8'h80, b=8'h7F.
  - Pulse start with a=8'h00, b=8'hFF two cycles later.
  - Require a single done 8 cycles after the first accept with gt=1, and no second done.
- Bit-position cases, WIDTH=8, each with a 8-cycle latency:
  - a=8'h01, b=8'h00 -> gt.
  - a=8'hA5, b=8'hA5 -> eq.
  - a=8'h7F, b=8'h80 -> lt.
- Reset mid-compare, WIDTH=8:
  - Accept a=5, b=3, then assert rst_n=0 asynchronously 3 cycles later, mid-cycle.
  - Require busy/gt/eq/lt=0 immediately and no done afterwards.
  - A fresh a=3, b=5 then returns lt.
- Back-to-back, WIDTH=4: hold start=1 with alternating operands.
  - Require done every 5 cycles, and each result matching the operands present on its accepting edge.
